mem_wb_pipe: RTL
================

// Module: mem_wb_pipe
// PURPOSE
//  Parametrised MEM->WB pipeline stage with valid tracking, stall, flush and a configurable delay depth.
//  Sits between the data-memory stage and the register-file write port; it replaces the fixed single-stage MEM/WB latch.
//  Exposes two forwarding lookup ports across all in-flight entries, a pre-muxed write-back value and a commit counter.
// PARAMETERS
//  DATA_W   32  width of memory read data and ALU result
//  REG_W    5   width of destination register index
//  STAGES   1   pipeline depth, legal 1..4 (latency in cycles)
//  CNT_W    32  width of commit counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous reset, active-high
//  stall          in   1       hold all stages
//  flush          in   1       kill all in-flight entries
//  in_valid       in   1       stage-0 input carries a real instruction
//  WB_ctl_in      in   2       [1]=RegWrite, [0]=MEMtoReg
//  RD_in          in   DATA_W  data-memory read data
//  ALU_result_in  in   DATA_W  ALU result
//  regdst_in      in   REG_W   destination register index
//  fwd_addr_a     in   REG_W   forwarding query A
//  fwd_addr_b     in   REG_W   forwarding query B
//  valid_out      out  1       last stage holds a valid entry
//  RegWrite       out  1       last-stage RegWrite, gated by valid_out
//  MEMtoReg       out  1       last-stage MEMtoReg, gated by valid_out
//  RD_out         out  DATA_W  last-stage read data
//  ALU_result_out out  DATA_W  last-stage ALU result
//  regdst_out     out  REG_W   last-stage destination index
//  wb_data        out  DATA_W  MEMtoReg ? RD_out : ALU_result_out
//  fwd_hit_a/b    out  1       query hit
//  fwd_data_a/b   out  DATA_W  forwarded value on hit, else 0
//  commit_count   out  CNT_W   number of committed register writes
// BEHAVIOUR
//  - Each stage k holds {valid, regwrite, memtoreg, rd, alu, dst}. Stage STAGES-1 drives the outputs.
//  - Priority per posedge: rst > flush > stall > advance.
//  - rst: all stage fields are set to 0. commit_count, valid_out, RegWrite, MEMtoReg, RD_out, ALU_result_out, regdst_out and wb_data are all 0.
//  - flush: every stage's valid, regwrite and memtoreg are cleared to 0. Data and dst fields are cleared to 0. flush overrides a simultaneous stall.
//  - stall (no flush): every stage holds its value. The inputs are ignored and commit_count holds.
//  - advance: stage0 <= inputs, with valid=in_valid. If in_valid=0, stage0 regwrite/memtoreg are forced to 0 and the data fields are still captured.
//    Stage k <= stage k-1 for k>=1.
//  - Latency: an input accepted at edge N appears on the outputs after edge N+STAGES-1, i.e. STAGES edges in total, with no stall.
//  - RegWrite = valid_out & stage regwrite. MEMtoReg = valid_out & stage memtoreg.
//  - commit_count increments by 1, wrapping at 2^CNT_W, on an advance edge where the last stage has valid & regwrite before the edge.
//    It does not increment on flush, stall or rst edges.
//  - Forwarding is combinational from registered state only; there is no input-to-output path.
//    - A stage matches when valid & regwrite & dst==addr & addr!=0.
//    - The lowest-index (youngest) matching stage wins.
//    - fwd_data = matching stage memtoreg ? rd : alu.
//    - With no match, hit=0 and data=0. Register index 0 never hits.
//  - Rst or flush mid-stream drops all in-flight entries. No RegWrite is asserted on the next cycle.
//  - An elaboration error is raised when STAGES<1 or STAGES>4.
// TESTING
//  - Reset: assert rst for 2 cycles with random inputs -> all outputs 0 and commit_count=0.
//  - STAGES=1 passthrough: in_valid=1, ctl=2'b10, ALU=0x1234, dst=5 -> next cycle RegWrite=1, wb_data=0x1234, regdst_out=5. One cycle later commit_count=1.
//  - STAGES=3 latency+stall: send A then B, and stall for 2 cycles after A enters -> A reaches the outputs at edge 3+2=5, B one cycle later. Order is preserved and there are no duplicates.
//  - Flush+stall same cycle with 3 valid entries -> all valid=0 next cycle, RegWrite stays 0 and commit_count is unchanged.
//  - Forward priority, STAGES=3: stage0 dst=7 ALU=0xA, stage2 dst=7 RD=0xB memtoreg=1, query 7 -> hit=1 with data 0xA. Query 0 -> hit=0.
//  - Counter wrap: CNT_W=4, run 17 committed writes -> commit_count=1. Entries with regwrite=0 are not counted.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage of configurable depth with valid tracking, stall/flush,
// forwarding lookup across all in-flight entries and a register-write commit counter.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        WB_ctl_in,
  input  logic [DATA_W-1:0] RD_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [REG_W-1:0]  regdst_in,
  input  logic [REG_W-1:0]  fwd_addr_a,
  input  logic [REG_W-1:0]  fwd_addr_b,
  output logic              valid_out,
  output logic              RegWrite,
  output logic              MEMtoReg,
  output logic [DATA_W-1:0] RD_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [REG_W-1:0]  regdst_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CNT_W-1:0]  commit_count
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mem_wb_pipe: STAGES must be in 1..4");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] rw_q;
  logic [STAGES-1:0] m2r_q;
  logic [DATA_W-1:0] rd_q  [STAGES];
  logic [DATA_W-1:0] alu_q [STAGES];
  logic [REG_W-1:0]  dst_q [STAGES];
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      rw_q    <= '0;
      m2r_q   <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        rd_q[k]  <= '0;
        alu_q[k] <= '0;
        dst_q[k] <= '0;
      end
      if (rst) begin
        cnt_q <= '0;
      end
    end else if (!stall) begin
      // The entry leaving the last stage on this edge is the one that commits.
      if (valid_q[STAGES-1] && rw_q[STAGES-1]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      valid_q[0] <= in_valid;
      rw_q[0]    <= in_valid & WB_ctl_in[1];
      m2r_q[0]   <= in_valid & WB_ctl_in[0];
      rd_q[0]    <= RD_in;
      alu_q[0]   <= ALU_result_in;
      dst_q[0]   <= regdst_in;
      for (int k = 1; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_q[k-1];
        rw_q[k]    <= rw_q[k-1];
        m2r_q[k]   <= m2r_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        alu_q[k]   <= alu_q[k-1];
        dst_q[k]   <= dst_q[k-1];
      end
    end
  end

  assign valid_out      = valid_q[STAGES-1];
  assign RegWrite       = valid_q[STAGES-1] & rw_q[STAGES-1];
  assign MEMtoReg       = valid_q[STAGES-1] & m2r_q[STAGES-1];
  assign RD_out         = rd_q[STAGES-1];
  assign ALU_result_out = alu_q[STAGES-1];
  assign regdst_out     = dst_q[STAGES-1];
  assign wb_data        = MEMtoReg ? RD_out : ALU_result_out;
  assign commit_count   = cnt_q;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (valid_q[k] && rw_q[k] && (dst_q[k] == fwd_addr_a) && (fwd_addr_a != '0)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = m2r_q[k] ? rd_q[k] : alu_q[k];
      end
      if (valid_q[k] && rw_q[k] && (dst_q[k] == fwd_addr_b) && (fwd_addr_b != '0)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = m2r_q[k] ? rd_q[k] : alu_q[k];
      end
    end
  end

endmodule
